usb_ep_arbiter: RTL and testbench



---
 rtl/usb_pkg.sv | 13 +
 rtl/usb_ep_arbiter_rr_pick.sv | 29 ++
 rtl/usb_ep_arbiter.sv | 107 ++++++++++
 tb/tb_usb_ep_arbiter.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/usb_pkg.sv
// Shared definitions for the USB endpoint-side blocks: arbiter state encoding
// and the default grant-hold limit.
package usb_pkg;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_e;

    localparam int HOLD_LIMIT_DEFAULT = 1024;
    localparam int HOLD_CNT_W         = 16;

endpackage

// File: rtl/usb_ep_arbiter_rr_pick.sv
// Combinational round-robin winner search: scans upward from last_winner+1
// with wrap-around and reports the first requester found.
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int SEL_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [SEL_W-1:0]   last_winner,
    output logic [SEL_W-1:0]   winner,
    output logic               any_req
);

    int idx;

    // Offset 1 is checked first so the previous winner gets lowest priority.
    always_comb begin
        winner  = '0;
        any_req = 1'b0;
        idx     = 0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = (int'(last_winner) + i) % NUM_REQ;
            if (!any_req && req[idx]) begin
                any_req = 1'b1;
                winner  = SEL_W'(idx);
            end
        end
    end

endmodule

// File: rtl/usb_ep_arbiter.sv
// Round-robin arbiter granting one endpoint handler at a time access to the
// shared endpoint buffer, with a sticky flag for grants held too long.
module usb_ep_arbiter
    import usb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int HOLD_LIMIT = HOLD_LIMIT_DEFAULT
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req,
    output logic [NUM_REQ-1:0]         grant,
    input  logic [NUM_REQ-1:0]         data_get_in,
    output logic                       buf_data_get,
    output logic [$clog2(NUM_REQ)-1:0] ep_sel,
    output logic                       busy,
    output logic                       hold_timeout
);

    localparam int SEL_W = $clog2(NUM_REQ);
    localparam logic [HOLD_CNT_W-1:0] HOLD_MAX = '1;

    arb_state_e              state_q, state_d;
    logic [NUM_REQ-1:0]      grant_q, grant_d;
    logic [SEL_W-1:0]        last_winner_q, last_winner_d;
    logic [SEL_W-1:0]        ep_sel_q, ep_sel_d;
    logic [HOLD_CNT_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic                    timeout_q, timeout_d;

    logic [SEL_W-1:0]        winner;
    logic                    any_req;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .SEL_W   (SEL_W)
    ) u_rr_pick (
        .req         (req),
        .last_winner (last_winner_q),
        .winner      (winner),
        .any_req     (any_req)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ARB_IDLE;
            grant_q       <= '0;
            last_winner_q <= SEL_W'(NUM_REQ - 1);
            ep_sel_q      <= '0;
            hold_cnt_q    <= '0;
            timeout_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            last_winner_q <= last_winner_d;
            ep_sel_q      <= ep_sel_d;
            hold_cnt_q    <= hold_cnt_d;
            timeout_q     <= timeout_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        last_winner_d = last_winner_q;
        ep_sel_d      = ep_sel_q;
        hold_cnt_d    = hold_cnt_q;
        timeout_d     = timeout_q;
        unique case (state_q)
            ARB_IDLE: begin
                grant_d = '0;
                if (any_req) begin
                    state_d       = ARB_GRANT;
                    grant_d       = NUM_REQ'(1) << winner;
                    last_winner_d = winner;
                    ep_sel_d      = winner;
                    hold_cnt_d    = '0;
                    timeout_d     = 1'b0;
                end
            end
            ARB_GRANT: begin
                // Only the grantee's own request matters; others cannot preempt.
                if (req[ep_sel_q]) begin
                    if (hold_cnt_q != HOLD_MAX) begin
                        hold_cnt_d = hold_cnt_q + 1'b1;
                    end
                    if (hold_cnt_d == HOLD_CNT_W'(HOLD_LIMIT)) begin
                        timeout_d = 1'b1;
                    end
                end else begin
                    state_d = ARB_IDLE;
                    grant_d = '0;
                end
            end
            default: begin
                state_d = ARB_IDLE;
                grant_d = '0;
            end
        endcase
    end

    assign grant        = grant_q;
    assign ep_sel       = ep_sel_q;
    assign busy         = |grant_q;
    assign hold_timeout = timeout_q;
    assign buf_data_get = data_get_in[ep_sel_q] & grant_q[ep_sel_q];

endmodule

// File: tb/tb_usb_ep_arbiter.sv
// Directed self-checking bench for usb_ep_arbiter: each step pushes its expected
// outputs into a scoreboard queue, clocks the DUT, then pops and compares.
module tb_usb_ep_arbiter;

    logic       clk;
    logic       reset;
    logic [3:0] req;
    logic [3:0] grant;
    logic [3:0] data_get_in;
    logic       buf_data_get;
    logic [1:0] ep_sel;
    logic       busy;
    logic       hold_timeout;

    typedef struct {
        logic [3:0] grant;
        logic [1:0] sel;
        logic       busy;
        logic       bdg;
        logic       tmo;
    } exp_t;

    exp_t  exp_q[$];
    string tag_q[$];
    int    tests_run;
    int    tests_failed;

    usb_ep_arbiter #(
        .NUM_REQ    (4),
        .HOLD_LIMIT (8)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req          (req),
        .grant        (grant),
        .data_get_in  (data_get_in),
        .buf_data_get (buf_data_get),
        .ep_sel       (ep_sel),
        .busy         (busy),
        .hold_timeout (hold_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput();
        exp_t  e;
        string t;
        tests_run++;
        assert (exp_q.size() != 0) else begin
            tests_failed++;
            $error("[TB] FAIL scoreboard: observed empty queue, expected an entry");
        end
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            tests_run++;
            assert (grant === e.grant) else begin
                tests_failed++;
                $error("[TB] FAIL %s grant: observed %b expected %b", t, grant, e.grant);
            end
            tests_run++;
            assert (ep_sel === e.sel) else begin
                tests_failed++;
                $error("[TB] FAIL %s ep_sel: observed %0d expected %0d", t, ep_sel, e.sel);
            end
            tests_run++;
            assert (busy === e.busy) else begin
                tests_failed++;
                $error("[TB] FAIL %s busy: observed %b expected %b", t, busy, e.busy);
            end
            tests_run++;
            assert (buf_data_get === e.bdg) else begin
                tests_failed++;
                $error("[TB] FAIL %s buf_data_get: observed %b expected %b", t, buf_data_get, e.bdg);
            end
            tests_run++;
            assert (hold_timeout === e.tmo) else begin
                tests_failed++;
                $error("[TB] FAIL %s hold_timeout: observed %b expected %b", t, hold_timeout, e.tmo);
            end
        end
    endtask

    task automatic applyStimulus(input logic [3:0] r, input logic [3:0] dg,
                                 input logic [3:0] eg, input logic [1:0] esel,
                                 input logic ebdg, input logic etmo, input string tag);
        exp_t e;
        req         = r;
        data_get_in = dg;
        e.grant = eg;
        e.sel   = esel;
        e.busy  = |eg;
        e.bdg   = ebdg;
        e.tmo   = etmo;
        exp_q.push_back(e);
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset        = 1'b1;
        req          = '0;
        data_get_in  = '0;

        // Reset state
        applyStimulus(4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, "reset");
        applyStimulus(4'b1111, 4'b1111, 4'b0000, 2'd0, 1'b0, 1'b0, "reset_held");
        reset = 1'b0;

        // Simultaneous requests: rotation 0,1,2,3,0 with an idle gap each time
        applyStimulus(4'b1111, 4'b0000, 4'b0001, 2'd0, 1'b0, 1'b0, "rr_g0");
        applyStimulus(4'b1110, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, "rr_gap0");
        applyStimulus(4'b1111, 4'b0000, 4'b0010, 2'd1, 1'b0, 1'b0, "rr_g1");
        applyStimulus(4'b1101, 4'b0000, 4'b0000, 2'd1, 1'b0, 1'b0, "rr_gap1");
        applyStimulus(4'b1111, 4'b0000, 4'b0100, 2'd2, 1'b0, 1'b0, "rr_g2");
        applyStimulus(4'b1011, 4'b0000, 4'b0000, 2'd2, 1'b0, 1'b0, "rr_gap2");
        applyStimulus(4'b1111, 4'b0000, 4'b1000, 2'd3, 1'b0, 1'b0, "rr_g3");
        applyStimulus(4'b0111, 4'b0000, 4'b0000, 2'd3, 1'b0, 1'b0, "rr_gap3");
        applyStimulus(4'b1111, 4'b0000, 4'b0001, 2'd0, 1'b0, 1'b0, "rr_g0_again");
        applyStimulus(4'b1110, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, "rr_gap4");

        // All requests low: stays idle
        applyStimulus(4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, "idle_a");
        applyStimulus(4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, "idle_b");

        // Single requester: one-cycle latency, ep_sel held while idle afterwards
        applyStimulus(4'b0100, 4'b0000, 4'b0100, 2'd2, 1'b0, 1'b0, "single_grant");
        applyStimulus(4'b0100, 4'b0000, 4'b0100, 2'd2, 1'b0, 1'b0, "single_hold");
        applyStimulus(4'b0000, 4'b0000, 4'b0000, 2'd2, 1'b0, 1'b0, "single_release");

        // Non-preemption: req[0] raised while handler 1 holds the grant
        applyStimulus(4'b0010, 4'b0000, 4'b0010, 2'd1, 1'b0, 1'b0, "np_grant1");
        applyStimulus(4'b0011, 4'b0000, 4'b0010, 2'd1, 1'b0, 1'b0, "np_hold_a");
        applyStimulus(4'b0011, 4'b0000, 4'b0010, 2'd1, 1'b0, 1'b0, "np_hold_b");
        applyStimulus(4'b0001, 4'b0000, 4'b0000, 2'd1, 1'b0, 1'b0, "np_gap");
        applyStimulus(4'b0001, 4'b0000, 4'b0001, 2'd0, 1'b0, 1'b0, "np_grant0");
        applyStimulus(4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, "np_release");

        // data_get gating with handler 3 granted; a short req[1] pulse is lost
        applyStimulus(4'b1000, 4'b0000, 4'b1000, 2'd3, 1'b0, 1'b0, "dg_grant3");
        applyStimulus(4'b1010, 4'b1001, 4'b1000, 2'd3, 1'b1, 1'b0, "dg_pulse_a");
        applyStimulus(4'b1000, 4'b1001, 4'b1000, 2'd3, 1'b1, 1'b0, "dg_pulse_b");
        applyStimulus(4'b1000, 4'b0001, 4'b1000, 2'd3, 1'b0, 1'b0, "dg_bit0_only");
        applyStimulus(4'b1000, 4'b0000, 4'b1000, 2'd3, 1'b0, 1'b0, "dg_off");
        applyStimulus(4'b0000, 4'b0000, 4'b0000, 2'd3, 1'b0, 1'b0, "dg_release");
        applyStimulus(4'b0000, 4'b1111, 4'b0000, 2'd3, 1'b0, 1'b0, "dg_no_grant");
        applyStimulus(4'b0000, 4'b0000, 4'b0000, 2'd3, 1'b0, 1'b0, "lost_req1");

        // Timeout: handler 2 holds for 20 grant cycles, limit is 8
        applyStimulus(4'b0100, 4'b0000, 4'b0100, 2'd2, 1'b0, 1'b0, "to_grant");
        for (int k = 1; k <= 19; k++) begin
            applyStimulus(4'b0100, 4'b0000, 4'b0100, 2'd2, 1'b0, (k >= 8), $sformatf("to_hold%0d", k));
        end
        applyStimulus(4'b0000, 4'b0000, 4'b0000, 2'd2, 1'b0, 1'b1, "to_release");
        applyStimulus(4'b0000, 4'b0000, 4'b0000, 2'd2, 1'b0, 1'b1, "to_sticky_idle");
        applyStimulus(4'b0001, 4'b0000, 4'b0001, 2'd0, 1'b0, 1'b0, "to_clear");
        applyStimulus(4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, "to_done");

        // Reset mid-grant, then handler 0 wins first
        applyStimulus(4'b0010, 4'b0000, 4'b0010, 2'd1, 1'b0, 1'b0, "rst_grant1");
        applyStimulus(4'b0010, 4'b0010, 4'b0010, 2'd1, 1'b1, 1'b0, "rst_dg");
        reset = 1'b1;
        applyStimulus(4'b0010, 4'b0010, 4'b0000, 2'd0, 1'b0, 1'b0, "rst_mid");
        reset = 1'b0;
        applyStimulus(4'b0011, 4'b0000, 4'b0001, 2'd0, 1'b0, 1'b0, "rst_first0");
        applyStimulus(4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, "rst_release");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
